// File: rtl/cmp_minmax_scan.sv
// Burst min/max scanner wrapped around a shared 32-bit magnitude comparator.
// Each sample after the first is compared once against min, then once against max.
module cmp_minmax_scan #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             sign,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    output logic             cmp_sign,
    input  logic             cmp_gr,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic             cmp_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CMP_MIN = 3'd2,
        CMP_MAX = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic             sign_q;
    logic [WIDTH-1:0] sample_q;
    logic             xfer;
    logic             flags_ok;
    logic             last_cmp;
    logic             first;

    // Stream handshake: a sample moves on a rising edge where in_valid and
    // in_ready are both high; in_ready is high exactly while in FETCH, and
    // in_valid may stay low for any number of cycles without penalty.
    assign in_ready = (state == FETCH);
    assign xfer     = in_ready && in_valid;
    assign first    = (idx_q == '0);
    assign flags_ok = $onehot({cmp_gr, cmp_lt, cmp_eq});
    assign last_cmp = ((idx_q + CNT_W'(1)) == len_q);

    assign cmp_sign  = sign_q;
    assign cmp_a     = (state == CMP_MIN || state == CMP_MAX) ? sample_q : '0;
    assign cmp_b     = (state == CMP_MIN) ? min_val :
                       (state == CMP_MAX) ? max_val : '0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = (len == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (xfer) begin
                    if (first) state_nx = (len_q == CNT_W'(1)) ? DONE : FETCH;
                    else       state_nx = CMP_MIN;
                end
            end
            CMP_MIN: state_nx = CMP_MAX;
            CMP_MAX: state_nx = last_cmp ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            idx_q    <= '0;
            sign_q   <= 1'b0;
            sample_q <= '0;
            min_val  <= '0;
            max_val  <= '0;
            min_idx  <= '0;
            max_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            empty    <= 1'b0;
            cmp_err  <= 1'b0;
        end else begin
            done <= (state_nx == DONE);
            busy <= (state_nx == FETCH) || (state_nx == CMP_MIN) || (state_nx == CMP_MAX);
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        sign_q  <= sign;
                        idx_q   <= '0;
                        cmp_err <= 1'b0;
                        empty   <= 1'b0;
                        if (len == '0) begin
                            empty   <= 1'b1;
                            min_val <= '0;
                            max_val <= '0;
                            min_idx <= '0;
                            max_idx <= '0;
                        end
                    end
                end
                FETCH: begin
                    if (xfer) begin
                        // The first sample seeds both extremes without a compare.
                        if (first) begin
                            min_val <= in_data;
                            max_val <= in_data;
                            min_idx <= '0;
                            max_idx <= '0;
                            idx_q   <= CNT_W'(1);
                        end else begin
                            sample_q <= in_data;
                        end
                    end
                end
                CMP_MIN: begin
                    if (!flags_ok) begin
                        cmp_err <= 1'b1;
                    end else if (cmp_lt) begin
                        min_val <= sample_q;
                        min_idx <= idx_q;
                    end
                end
                CMP_MAX: begin
                    if (!flags_ok) begin
                        cmp_err <= 1'b1;
                    end else if (cmp_gr) begin
                        max_val <= sample_q;
                        max_idx <= idx_q;
                    end
                    idx_q <= idx_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cmp_minmax_scan.md
Name: cmp_minmax_scan

Overview:
Sequential min/max scanner that sits around the ALU's 32-bit magnitude comparator. It drives the comparator operands and consumes its Gr/Lt/Eq flags in the same cycle. It accepts a burst of `len` 32-bit samples over a valid/ready stream and reports the running minimum and maximum plus the index of each. One shared comparator is time-multiplexed: one compare against min, then one against max.

Parameters:
WIDTH, 32, sample width; must match the comparator, only 32 is legal
CNT_W, 8, width of the burst length and index fields

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin burst; sampled only in IDLE
len  in  CNT_W  samples in the burst, captured at start; 0 allowed
sign  in  1  1 = signed compare, 0 = unsigned; captured at start
in_valid  in  1  sample valid
in_data  in  WIDTH  sample
in_ready  out  1  block can accept a sample
cmp_a  out  WIDTH  comparator operand a
cmp_b  out  WIDTH  comparator operand b
cmp_sign  out  1  comparator sign mode (captured sign)
cmp_gr  in  1  comparator a>b, combinational, same cycle
cmp_lt  in  1  comparator a<b
cmp_eq  in  1  comparator a==b
min_val  out  WIDTH  running minimum
max_val  out  WIDTH  running maximum
min_idx  out  CNT_W  index of min_val
max_idx  out  CNT_W  index of max_val
busy  out  1  burst in progress
done  out  1  one-cycle pulse at end of burst
empty  out  1  last burst had len=0
cmp_err  out  1  sticky: illegal flag triple seen during the burst

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0, including cmp_a/cmp_b. FSM goes to IDLE and internal counters clear. Reset mid-burst abandons the burst; no done pulse.
- All outputs are registered except in_ready, cmp_a, cmp_b and cmp_sign, which decode from state and registers.
- FSM states: IDLE, FETCH, CMP_MIN, CMP_MAX, DONE.
- IDLE:
  - On start=1: capture len and sign, clear idx counter, clear cmp_err and empty.
  - If len=0: go to DONE, set empty=1, clear min/max and both indices to 0.
  - Otherwise go to FETCH.
- FETCH:
  - in_ready=1. A transfer occurs when in_valid & in_ready; hold state otherwise (gaps allowed, no timeout).
  - First sample (idx=0): load min_val=max_val=in_data and min_idx=max_idx=0, with no compare. Go to DONE if len=1, else stay in FETCH.
  - Later samples: latch into sample register and go to CMP_MIN.
- CMP_MIN:
  - cmp_a=sample, cmp_b=min_val.
  - If cmp_lt: min_val=sample, min_idx=idx.
  - Go to CMP_MAX.
- CMP_MAX:
  - cmp_a=sample, cmp_b=max_val.
  - If cmp_gr: max_val=sample, max_idx=idx.
  - Increment idx. Go to DONE if idx+1==len, else FETCH.
- Flag check in CMP_MIN/CMP_MAX: if {cmp_gr,cmp_lt,cmp_eq} is not exactly one-hot, set cmp_err. Treat the sample as no-update for that compare and continue the burst.
- Ties: cmp_eq → no update. First occurrence index is retained for both min and max.
- DONE: done=1 for exactly this cycle, then IDLE. busy=1 in FETCH, CMP_MIN and CMP_MAX only.
- start outside IDLE is ignored. len/sign changes mid-burst have no effect.
- cmp_a and cmp_b are 0 outside compare states.
- Results hold after done until the next start.
- Latency, zero input gaps, start seen at cycle 0:
  - First sample accepted at cycle 1.
  - Each further sample costs 3 cycles.
  - done asserts at cycle 3N-1 for N≥1, and at cycle 1 for N=0.
- idx wrap: len ≤ 2^CNT_W-1, so the counter never wraps within a burst.

Test Plan:
1. Unsigned, len=4, samples 5,2,9,2 with no gaps → min_val=2, min_idx=1, max_val=9, max_idx=2, done at cycle 11, cmp_err=0.
2. Signed, len=3, samples 0x00000003, 0xFFFFFFFE, 0x7FFFFFFF → min_val=0xFFFFFFFE, min_idx=1, max_val=0x7FFFFFFF, max_idx=2. Same data unsigned → min_val=3, min_idx=0, max_val=0xFFFFFFFE, max_idx=1.
3. len=1, sample 0xA → min_val=max_val=0xA, indices 0, no compare cycles (cmp_a stays 0), done at cycle 2. len=0 → done at cycle 1, empty=1, min_val=max_val=0.
4. len=3 with in_valid low for 4 cycles before each sample, plus start pulsed during the burst → in_ready high only in FETCH, results correct, exactly one done pulse, second start ignored.
5. Comparator model forced to return 000 on the second sample's CMP_MIN → cmp_err=1 at end of burst, min_val unchanged by that sample. The next burst clears cmp_err.
6. rst_n asserted asynchronously during CMP_MAX of a len=5 burst → all outputs 0 immediately, no done pulse. A new burst after release runs normally.
